// File: rtl/udma_hyper_arb_pkg.sv
// Shared types for the hyperbus uDMA transaction arbiter.
// The request record is sized for the default address and size widths.
// Other widths are zero-extended into it on capture and truncated back out on output.
package udma_hyper_arb_pkg;

    localparam int unsigned ARB_AWIDTH = 12;
    localparam int unsigned ARB_SIZE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  rw;
        logic [ARB_AWIDTH-1:0] tx_addr;
        logic [ARB_SIZE_W-1:0] tx_size;
        logic [ARB_AWIDTH-1:0] rx_addr;
        logic [ARB_SIZE_W-1:0] rx_size;
    } req_cfg_t;

    // The id value that means "no transaction in flight".
    function automatic int unsigned idle_id(int unsigned id_width);
        return 32'd1 << id_width;
    endfunction

endpackage

// File: rtl/udma_hyper_rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at channel ptr and wraps modulo NB_CH.
// It returns a one-hot grant, the granted index, and an any-request flag.
module udma_hyper_rr_arbiter #(
    parameter int NB_CH    = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic [NB_CH-1:0]    req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NB_CH-1:0]    gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    // Walk the channels from ptr, wrapping, and take the first one requesting.
    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NB_CH; k++) begin
            c = int'(ptr) + k;
            if (c >= NB_CH) c = c - NB_CH;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = ID_WIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/udma_hyper_trans_arb.sv
// Round-robin owner of the single hyperbus uDMA transaction slot.
// On a grant it registers the winner's addresses and sizes.
// It then issues a one-cycle toudma pulse and waits for trans_done_i.
// A request whose selected-direction size is zero completes at once, without an issue.
// Optional feature macro: HYPER_ARB_TIMEOUT_EN.
// It adds a watchdog in WAIT that reports err_o to the owner channel.
module udma_hyper_trans_arb
    import udma_hyper_arb_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int NB_CH          = 2,
    parameter int ID_WIDTH       = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               cfg_en_i,
    input  logic [NB_CH-1:0]                   req_valid_i,
    output logic [NB_CH-1:0]                   req_ready_o,
    input  logic [NB_CH-1:0]                   req_rw_i,
    input  logic [NB_CH*L2_AWIDTH_NOAL-1:0]    req_tx_addr_i,
    input  logic [NB_CH*TRANS_SIZE-1:0]        req_tx_size_i,
    input  logic [NB_CH*L2_AWIDTH_NOAL-1:0]    req_rx_addr_i,
    input  logic [NB_CH*TRANS_SIZE-1:0]        req_rx_size_i,
    output logic [L2_AWIDTH_NOAL-1:0]          toudma_tx_start_addr_o,
    output logic [TRANS_SIZE-1:0]              toudma_tx_size_o,
    output logic [L2_AWIDTH_NOAL-1:0]          toudma_rx_start_addr_o,
    output logic [TRANS_SIZE-1:0]              toudma_rx_size_o,
    output logic                               toudma_rw_hyper_o,
    output logic                               toudma_trans_valid_o,
    output logic [ID_WIDTH:0]                  toudma_trans_id_o,
    input  logic                               trans_done_i,
    output logic [NB_CH-1:0]                   done_o,
    output logic [NB_CH-1:0]                   err_o,
    output logic                               busy_o
);

    localparam logic [ID_WIDTH:0] IDLE_CODE = (ID_WIDTH+1)'(idle_id(ID_WIDTH));

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] ptr_q, owner_q, gnt_idx;
    logic [NB_CH-1:0]    gnt, owner_oh, done_d, done_q, err_d;
    logic                gnt_any, grant, zero_len;
    req_cfg_t            sel_cfg, cfg_q;
    logic [ID_WIDTH:0]   id_q;

    udma_hyper_rr_arbiter #(
        .NB_CH    (NB_CH),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req (req_valid_i),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Slice out the candidate channel's request fields and flag an empty transfer.
    always_comb begin
        sel_cfg.rw      = req_rw_i[gnt_idx];
        sel_cfg.tx_addr = ARB_AWIDTH'(req_tx_addr_i[int'(gnt_idx)*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
        sel_cfg.tx_size = ARB_SIZE_W'(req_tx_size_i[int'(gnt_idx)*TRANS_SIZE +: TRANS_SIZE]);
        sel_cfg.rx_addr = ARB_AWIDTH'(req_rx_addr_i[int'(gnt_idx)*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
        sel_cfg.rx_size = ARB_SIZE_W'(req_rx_size_i[int'(gnt_idx)*TRANS_SIZE +: TRANS_SIZE]);
        zero_len        = sel_cfg.rw ? (sel_cfg.rx_size == '0) : (sel_cfg.tx_size == '0);
    end

    // Decode the current owner index to a one-hot channel vector.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

`ifdef HYPER_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic [NB_CH-1:0] err_q;
    // The expiry compare looks at cnt_q, so the pulse lands TIMEOUT_CYCLES after the issue.
    wire expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

    // Watchdog: cleared while issuing, counts every cycle spent waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            err_q <= err_d;
            if (state_q == ISSUE) cnt_q <= '0;
            else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

    // Next-state logic: grant in IDLE, issue for one cycle, wait for completion.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (cfg_en_i && gnt_any) begin
                    grant = 1'b1;
                    if (zero_len) done_d  = gnt;
                    else          state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (trans_done_i) begin
                    done_d  = owner_oh;
                    state_d = IDLE;
                end
`ifdef HYPER_ARB_TIMEOUT_EN
                else if (expire) begin
                    err_d   = owner_oh;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer, owner and captured request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cfg_q   <= '0;
            id_q    <= IDLE_CODE;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (grant) begin
                ptr_q   <= (int'(gnt_idx) == NB_CH - 1) ? '0 : gnt_idx + 1'b1;
                owner_q <= gnt_idx;
                cfg_q   <= sel_cfg;
                if (!zero_len) id_q <= {1'b0, gnt_idx};
            end else if (state_q == WAIT && state_d == IDLE) begin
                id_q <= IDLE_CODE;
            end
        end
    end

    assign req_ready_o            = (state_q == IDLE && cfg_en_i) ? gnt : '0;
    assign toudma_trans_valid_o   = (state_q == ISSUE);
    assign toudma_trans_id_o      = id_q;
    assign toudma_rw_hyper_o      = cfg_q.rw;
    assign toudma_tx_start_addr_o = L2_AWIDTH_NOAL'(cfg_q.tx_addr);
    assign toudma_tx_size_o       = TRANS_SIZE'(cfg_q.tx_size);
    assign toudma_rx_start_addr_o = L2_AWIDTH_NOAL'(cfg_q.rx_addr);
    assign toudma_rx_size_o       = TRANS_SIZE'(cfg_q.rx_size);
    assign done_o                 = done_q;
    assign busy_o                 = (state_q != IDLE);

endmodule

// File: tb/tb_udma_hyper_trans_arb.sv
// Directed bench for udma_hyper_trans_arb (NB_CH=2, TIMEOUT_CYCLES=8).
// A per-cycle vector table covers grant, issue, done, the zero-size shortcut,
// stray done pulses, cfg_en gating and alternation.
// Hand sequences cover data capture, reset in WAIT and the watchdog.
module tb_udma_hyper_trans_arb;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cfg_en;
    logic [1:0]  req_valid, req_ready, req_rw;
    logic [23:0] tx_addr, rx_addr;
    logic [31:0] tx_size, rx_size;
    logic [11:0] o_tx_addr, o_rx_addr;
    logic [15:0] o_tx_size, o_rx_size;
    logic        o_rw, o_tvalid, trans_done, busy;
    logic [1:0]  o_id, done, err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    udma_hyper_trans_arb #(
        .L2_AWIDTH_NOAL (12),
        .TRANS_SIZE     (16),
        .NB_CH          (2),
        .ID_WIDTH       (1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .cfg_en_i               (cfg_en),
        .req_valid_i            (req_valid),
        .req_ready_o            (req_ready),
        .req_rw_i               (req_rw),
        .req_tx_addr_i          (tx_addr),
        .req_tx_size_i          (tx_size),
        .req_rx_addr_i          (rx_addr),
        .req_rx_size_i          (rx_size),
        .toudma_tx_start_addr_o (o_tx_addr),
        .toudma_tx_size_o       (o_tx_size),
        .toudma_rx_start_addr_o (o_rx_addr),
        .toudma_rx_size_o       (o_rx_size),
        .toudma_rw_hyper_o      (o_rw),
        .toudma_trans_valid_o   (o_tvalid),
        .toudma_trans_id_o      (o_id),
        .trans_done_i           (trans_done),
        .done_o                 (done),
        .err_o                  (err),
        .busy_o                 (busy)
    );

    typedef struct {
        logic       cfg;
        logic [1:0] v;
        logic [1:0] rw;
        logic       td;
        logic [1:0] e_rdy;
        logic       e_tv;
        logic [1:0] e_id;
        logic [1:0] e_done;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic cfg, input logic [1:0] v, input logic [1:0] rw, input logic td,
                       input logic [1:0] rdy, input logic tv, input logic [1:0] id,
                       input logic [1:0] dn, input logic bsy);
        tbl.push_back('{cfg, v, rw, td, rdy, tv, id, dn, bsy});
    endtask

    task automatic drive(input logic cfg, input logic [1:0] v, input logic [1:0] rw, input logic td);
        cfg_en     = cfg;
        req_valid  = v;
        req_rw     = rw;
        trans_done = td;
    endtask

    initial begin
        // ch0: tx 0x100/16, rx 0x200/8; ch1: tx 0x300/4, rx 0x400/0
        tx_addr = {12'h300, 12'h100};
        tx_size = {16'd4, 16'd16};
        rx_addr = {12'h400, 12'h200};
        rx_size = {16'd0, 16'd8};
        rst_ni  = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 1'b0);

        //   cfg  v      rw     td    rdy    tv    id     done   busy
        add(1, 2'b01, 2'b00, 0, 2'b01, 0, 2'd2, 2'b00, 0); //  0 ch0 write granted
        add(1, 2'b00, 2'b00, 0, 2'b00, 1, 2'd0, 2'b00, 1); //  1 issue
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'd0, 2'b00, 1); //  2 wait
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'd0, 2'b00, 1); //  3
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'd0, 2'b00, 1); //  4
        add(1, 2'b00, 2'b00, 1, 2'b00, 0, 2'd0, 2'b00, 1); //  5 done in
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'd2, 2'b01, 0); //  6 done_o[0]
        add(1, 2'b00, 2'b00, 1, 2'b00, 0, 2'd2, 2'b00, 0); //  7 stray done in IDLE
        add(1, 2'b10, 2'b10, 0, 2'b10, 0, 2'd2, 2'b00, 0); //  8 ch1 read, rx size 0
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'd2, 2'b10, 0); //  9 shortcut done_o[1]
        add(1, 2'b01, 2'b00, 1, 2'b01, 0, 2'd2, 2'b00, 0); // 10 grant with stray done
        add(1, 2'b00, 2'b00, 1, 2'b00, 1, 2'd0, 2'b00, 1); // 11 stray done in ISSUE
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'd0, 2'b00, 1); // 12 no done_o
        add(0, 2'b11, 2'b00, 0, 2'b00, 0, 2'd0, 2'b00, 1); // 13 cfg_en dropped in WAIT
        add(0, 2'b11, 2'b00, 1, 2'b00, 0, 2'd0, 2'b00, 1); // 14 still completes
        add(0, 2'b11, 2'b00, 0, 2'b00, 0, 2'd2, 2'b01, 0); // 15 done, no grant
        add(0, 2'b11, 2'b00, 0, 2'b00, 0, 2'd2, 2'b00, 0); // 16 still blocked
        add(1, 2'b11, 2'b00, 0, 2'b10, 0, 2'd2, 2'b00, 0); // 17 ch1 (ptr=1)
        add(1, 2'b11, 2'b00, 0, 2'b00, 1, 2'd1, 2'b00, 1); // 18
        add(1, 2'b11, 2'b00, 1, 2'b00, 0, 2'd1, 2'b00, 1); // 19
        add(1, 2'b11, 2'b00, 0, 2'b01, 0, 2'd2, 2'b10, 0); // 20 ch0 re-granted
        add(1, 2'b11, 2'b00, 0, 2'b00, 1, 2'd0, 2'b00, 1); // 21 issue-to-issue 3
        add(1, 2'b11, 2'b00, 1, 2'b00, 0, 2'd0, 2'b00, 1); // 22
        add(1, 2'b11, 2'b00, 0, 2'b10, 0, 2'd2, 2'b01, 0); // 23 ch1
        add(1, 2'b00, 2'b00, 0, 2'b00, 1, 2'd1, 2'b00, 1); // 24
        add(1, 2'b00, 2'b00, 1, 2'b00, 0, 2'd1, 2'b00, 1); // 25
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 2'd2, 2'b10, 0); // 26

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_id", 32'(o_id), 32'd2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_addr", 32'(o_tx_addr), 32'd0);
        rst_ni = 1'b1;

        // Table-driven cycles
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].cfg, tbl[i].v, tbl[i].rw, tbl[i].td);
            #1;
            check($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            check($sformatf("row%0d_tvalid", i), 32'(o_tvalid), 32'(tbl[i].e_tv));
            check($sformatf("row%0d_id", i), 32'(o_id), 32'(tbl[i].e_id));
            check($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("row%0d_err", i), 32'(err), 32'd0);
        end

        // Data capture: ch0 read (ptr is back at 0)
        @(negedge clk);
        drive(1'b1, 2'b01, 2'b01, 1'b0);
        #1;
        check("rd_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        #1;
        check("rd_tvalid", 32'(o_tvalid), 32'd1);
        check("rd_rw", 32'(o_rw), 32'd1);
        check("rd_rx_addr", 32'(o_rx_addr), 32'h200);
        check("rd_rx_size", 32'(o_rx_size), 32'd8);
        check("rd_tx_addr", 32'(o_tx_addr), 32'h100);
        check("rd_tx_size", 32'(o_tx_size), 32'd16);
        @(negedge clk);
        #1;
        check("rd_hold_rx_addr", 32'(o_rx_addr), 32'h200);
        check("rd_wait_busy", 32'(busy), 32'd1);

        // Reset asserted in WAIT
        rst_ni = 1'b0;
        #1;
        check("wrst_id", 32'(o_id), 32'd2);
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_rw", 32'(o_rw), 32'd0);
        check("wrst_rx_addr", 32'(o_rx_addr), 32'd0);
        check("wrst_rx_size", 32'(o_rx_size), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Watchdog: ch0 write issued, never completed
        @(negedge clk);
        drive(1'b1, 2'b01, 2'b00, 1'b0);
        #1;
        check("to_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        #1;
        check("to_tvalid", 32'(o_tvalid), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
`ifdef HYPER_ARB_TIMEOUT_EN
            check($sformatf("to_err_c%0d", k), 32'(err), (k == 8) ? 32'h1 : 32'h0);
            check($sformatf("to_busy_c%0d", k), 32'(busy), (k == 8) ? 32'd0 : 32'd1);
            check($sformatf("to_done_c%0d", k), 32'(done), 32'd0);
`else
            check($sformatf("to_err_c%0d", k), 32'(err), 32'h0);
            check($sformatf("to_busy_c%0d", k), 32'(busy), 32'd1);
`endif
        end
`ifdef HYPER_ARB_TIMEOUT_EN
        check("to_idle_id", 32'(o_id), 32'd2);
`else
        // Without the watchdog only trans_done_i ends the wait
        @(negedge clk);
        trans_done = 1'b1;
        @(negedge clk);
        trans_done = 1'b0;
        #1;
        check("to_late_done", 32'(done), 32'h1);
        check("to_late_idle", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
